// File: rtl/fifo_param_pkg.sv
// Shared defaults and small helpers for the parametrised FIFO.
// Channel-level blocks import this package to pick up the common
// width/threshold defaults so every channel buffer is sized alike.
package fifo_param_pkg;

  // Default geometry and status thresholds of a channel FIFO.
  localparam int FIFO_DATA_W    = 10;
  localparam int FIFO_ADDR_W    = 3;
  localparam int FIFO_AF_THRESH = 6;
  localparam int FIFO_AE_THRESH = 2;

  // Per-cycle operation actually performed, after full/empty gating.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // Combine the accepted write/read strobes into one operation code.
  function automatic fifo_op_e fifo_op(input logic wr_acc, input logic rd_acc);
    return fifo_op_e'({wr_acc, rd_acc});
  endfunction

endpackage

// File: rtl/fifo_param_mem.sv
// Dual-port storage for fifo_param: one write port and one registered
// read port. The array itself is never reset; only the read register is.
module fifo_param_mem
  import fifo_param_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  // Store the incoming word; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read: load on a read strobe, otherwise hold data and drop valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data  <= {DATA_W{1'b0}};
      r_rd_valid <= 1'b0;
    end else if (i_rd_en) begin
      r_rd_data  <= r_mem[i_rd_addr];
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_data  <= r_rd_data;
      r_rd_valid <= 1'b0;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO. Owns the read/write pointers, the
// occupancy counter, the status flags and the sticky error flags; the
// storage lives in fifo_param_mem. Full/empty come from the counter, not
// from pointer comparison, so the pointers can simply wrap.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AF_THRESH = FIFO_AF_THRESH,
  parameter int AE_THRESH = FIFO_AE_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enb,
  input  logic              rd_enb,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] L_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] L_AF    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] L_AE    = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0] L_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] L_ONE   = (ADDR_W+1)'(1'b1);
  localparam logic [ADDR_W-1:0] L_PTR_ONE = ADDR_W'(1'b1);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_almost_full;
  logic              w_almost_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [ADDR_W:0]   w_count_nxt;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_valid;
  fifo_op_e          w_op;

  // Status flags decoded from the registered occupancy.
  always_comb begin
    w_full         = 1'b0;
    w_empty        = 1'b0;
    w_almost_full  = 1'b0;
    w_almost_empty = 1'b0;
    if (r_count == L_DEPTH) begin
      w_full = 1'b1;
    end else begin
      w_full = 1'b0;
    end
    if (r_count == L_ZERO) begin
      w_empty = 1'b1;
    end else begin
      w_empty = 1'b0;
    end
    if (r_count >= L_AF) begin
      w_almost_full = 1'b1;
    end else begin
      w_almost_full = 1'b0;
    end
    if (r_count <= L_AE) begin
      w_almost_empty = 1'b1;
    end else begin
      w_almost_empty = 1'b0;
    end
  end

  // Acceptance uses the flags registered before this edge; when full the
  // read wins, when empty the write wins (no write-to-read bypass).
  assign w_wr_acc = wr_enb & ~w_full;
  assign w_rd_acc = rd_enb & ~w_empty;
  assign w_op     = fifo_op(w_wr_acc, w_rd_acc);

  // Next occupancy from the accepted operation pair.
  always_comb begin
    w_count_nxt = r_count;
    case (w_op)
      OP_WRITE: w_count_nxt = r_count + L_ONE;
      OP_READ:  w_count_nxt = r_count - L_ONE;
      OP_BOTH:  w_count_nxt = r_count;
      OP_IDLE:  w_count_nxt = r_count;
      default:  w_count_nxt = r_count;
    endcase
  end

  // Pointer and occupancy state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= {ADDR_W{1'b0}};
      r_rd_ptr <= {ADDR_W{1'b0}};
      r_count  <= L_ZERO;
    end else begin
      r_count <= w_count_nxt;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      end
    end
  end

  // Sticky error flags: set by any rejected request, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_enb && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_enb && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  fifo_param_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_wr_acc),
    .i_wr_addr  (r_wr_ptr),
    .i_wr_data  (data_in),
    .i_rd_en    (w_rd_acc),
    .i_rd_addr  (r_rd_ptr),
    .o_rd_data  (w_rd_data),
    .o_rd_valid (w_rd_valid)
  );

  assign data_out     = w_rd_data;
  assign valid_out    = w_rd_valid;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = w_almost_full;
  assign almost_empty = w_almost_empty;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
